// File: rtl/rv_p4_pkg.sv
// rv_p4_pkg: CSR map and command FSM state type
// shared by the APB table port files.
package rv_p4_pkg;

   localparam int unsigned TBLP_CTRL      = 32'h000;
   localparam int unsigned TBLP_STATUS    = 32'h004;
   localparam int unsigned TBLP_INDEX     = 32'h008;
   localparam int unsigned TBLP_DATA_BASE = 32'h080;

   typedef enum logic [1:0] {
      TBLP_IDLE,
      TBLP_REQ,
      TBLP_WAIT
   } tblp_state_e;

   function automatic int unsigned tblp_word(
      input int unsigned off
   );
      return off >> 2;
   endfunction

endpackage

// File: rtl/apb_tbl_port_if.sv
// apb_tbl_port_if: APB3 slot plus table
// request/response signals for one table.
interface apb_tbl_port_if #(
   parameter int ADDR_W  = 12,
   parameter int ENTRY_W = 256,
   parameter int IDX_W   = 10
);
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [ADDR_W-1:0]  paddr;
   logic [31:0]        pwdata;
   logic [31:0]        prdata;
   logic               pready;
   logic               pslverr;

   logic               tbl_req_valid;
   logic               tbl_req_ready;
   logic               tbl_req_wr;
   logic [IDX_W-1:0]   tbl_req_idx;
   logic [ENTRY_W-1:0] tbl_req_wdata;
   logic               tbl_rsp_valid;
   logic [ENTRY_W-1:0] tbl_rsp_rdata;
   logic               tbl_rsp_err;

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr,
      output tbl_req_valid, tbl_req_wr,
      output tbl_req_idx, tbl_req_wdata,
      input  tbl_req_ready,
      input  tbl_rsp_valid, tbl_rsp_rdata,
      input  tbl_rsp_err
   );

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr,
      input  tbl_req_valid, tbl_req_wr,
      input  tbl_req_idx, tbl_req_wdata,
      output tbl_req_ready,
      output tbl_rsp_valid, tbl_rsp_rdata,
      output tbl_rsp_err
   );

endinterface

// File: rtl/apb_tbl_cmd_fsm.sv
// apb_tbl_cmd_fsm: table command sequencer with
// request handshake and response timeout.
module apb_tbl_cmd_fsm
   import rv_p4_pkg::*;
#(
   parameter int ENTRY_W = 256,
   parameter int IDX_W   = 10,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               start_wr,
   input  logic [IDX_W-1:0]   start_idx,
   input  logic [ENTRY_W-1:0] start_wdata,
   input  logic               req_ready,
   input  logic               rsp_valid,
   input  logic               rsp_err,
   output logic               busy,
   output logic               req_valid,
   output logic               req_wr,
   output logic [IDX_W-1:0]   req_idx,
   output logic [ENTRY_W-1:0] req_wdata,
   output logic               done,
   output logic               done_err,
   output logic               load
);

   localparam int CW = $clog2(TIMEOUT + 1);

   tblp_state_e   state_q;
   tblp_state_e   state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= TBLP_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // request fields are frozen for the whole command
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_wr    <= 1'b0;
         req_idx   <= '0;
         req_wdata <= '0;
      end else if (state_q == TBLP_IDLE && start) begin
         req_wr    <= start_wr;
         req_idx   <= start_idx;
         req_wdata <= start_wdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      done_err = 1'b0;
      load     = 1'b0;
      unique case (state_q)
         TBLP_IDLE: begin
            if (start) begin
               state_d = TBLP_REQ;
            end
         end
         TBLP_REQ: begin
            if (req_ready) begin
               state_d = TBLP_WAIT;
               cnt_d   = '0;
            end
         end
         TBLP_WAIT: begin
            if (rsp_valid) begin
               state_d  = TBLP_IDLE;
               done     = 1'b1;
               done_err = rsp_err;
               load     = ~req_wr & ~rsp_err;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               state_d  = TBLP_IDLE;
               done     = 1'b1;
               done_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = TBLP_IDLE;
      endcase
   end

   assign busy      = (state_q != TBLP_IDLE);
   assign req_valid = (state_q == TBLP_REQ);

endmodule

// File: rtl/apb_tbl_port.sv
// apb_tbl_port: APB3 CSR front end that stages a
// table entry and launches table read/write commands.
module apb_tbl_port
   import rv_p4_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int ENTRY_W = 256,
   parameter int IDX_W   = 10,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk_ctrl,
   input  logic           rst_ctrl,
   apb_tbl_port_if.slave  bus
);

   localparam int NW = ENTRY_W / 32;
   localparam int AW = ADDR_W - 2;

   logic [AW-1:0]        waddr;
   logic                 acc1;
   logic                 commit;
   logic                 pready_q;
   logic                 pslverr_q;
   logic [31:0]          prdata_q;
   logic                 hit_ctrl;
   logic                 hit_stat;
   logic                 hit_idx;
   logic                 hit_data;
   logic [NW-1:0]        hit_word;
   logic [31:0]          drd;
   logic [31:0]          rdata;
   logic                 err_c;
   logic                 op_q;
   logic                 done_q;
   logic                 err_q;
   logic [IDX_W-1:0]     index_q;
   logic [NW-1:0][31:0]  data_q;
   logic                 busy;
   logic                 go;
   logic                 fsm_done;
   logic                 fsm_err;
   logic                 fsm_load;
   logic                 unused_ok;

   assign waddr     = bus.paddr[ADDR_W-1:2];
   assign unused_ok = ^bus.paddr[1:0];
   assign acc1      = bus.psel & bus.penable & ~pready_q;
   // error decision is taken in the first ACCESS cycle
   assign commit    = bus.psel & bus.penable & pready_q &
                      bus.pwrite & ~pslverr_q;
   assign go        = commit & hit_ctrl & bus.pwdata[0];

   assign hit_ctrl = waddr == AW'(tblp_word(TBLP_CTRL));
   assign hit_stat = waddr == AW'(tblp_word(TBLP_STATUS));
   assign hit_idx  = waddr == AW'(tblp_word(TBLP_INDEX));
   assign hit_data = |hit_word;

   always_comb begin
      hit_word = '0;
      drd      = '0;
      for (int i = 0; i < NW; i++) begin
         if (waddr == AW'(tblp_word(TBLP_DATA_BASE) + i)) begin
            hit_word[i] = 1'b1;
            drd         = data_q[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         hit_ctrl: rdata = {30'b0, op_q, 1'b0};
         hit_stat: rdata = {29'b0, err_q, done_q, busy};
         hit_idx:  rdata = 32'(index_q);
         hit_data: rdata = drd;
         default:  rdata = '0;
      endcase
      err_c = ~(hit_ctrl | hit_stat | hit_idx | hit_data) |
              (bus.pwrite & busy & ~hit_stat);
   end

   always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
      if (rst_ctrl) begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= acc1;
         pslverr_q <= acc1 & err_c;
         prdata_q  <= (acc1 & ~err_c & ~bus.pwrite) ? rdata : '0;
      end
   end

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign bus.prdata  = prdata_q;

   always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
      if (rst_ctrl) begin
         op_q    <= 1'b0;
         index_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (commit & hit_ctrl) op_q <= bus.pwdata[1];
         if (commit & hit_idx) index_q <= bus.pwdata[IDX_W-1:0];
         for (int i = 0; i < NW; i++) begin
            if (commit & hit_word[i]) data_q[i] <= bus.pwdata;
         end
         if (fsm_load) data_q <= bus.tbl_rsp_rdata;
         // hardware set beats a same-cycle W1C
         if (go) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end else if (fsm_done) begin
            done_q <= 1'b1;
            err_q  <= fsm_err;
         end else if (commit & hit_stat) begin
            if (bus.pwdata[1]) done_q <= 1'b0;
            if (bus.pwdata[2]) err_q  <= 1'b0;
         end
      end
   end

   apb_tbl_cmd_fsm #(
      .ENTRY_W (ENTRY_W),
      .IDX_W   (IDX_W),
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk         (clk_ctrl),
      .rst         (rst_ctrl),
      .start       (go),
      .start_wr    (~bus.pwdata[1]),
      .start_idx   (index_q),
      .start_wdata (data_q),
      .req_ready   (bus.tbl_req_ready),
      .rsp_valid   (bus.tbl_rsp_valid),
      .rsp_err     (bus.tbl_rsp_err),
      .busy        (busy),
      .req_valid   (bus.tbl_req_valid),
      .req_wr      (bus.tbl_req_wr),
      .req_idx     (bus.tbl_req_idx),
      .req_wdata   (bus.tbl_req_wdata),
      .done        (fsm_done),
      .done_err    (fsm_err),
      .load        (fsm_load)
   );

endmodule

// File: tb/tb_apb_tbl_port.sv
// tb_apb_tbl_port: directed vector bench for the
// APB table port CSRs and command sequencing.
module tb_apb_tbl_port;

   localparam int ADDR_W  = 12;
   localparam int ENTRY_W = 256;
   localparam int IDX_W   = 10;
   localparam int TIMEOUT = 1024;
   localparam int NW      = ENTRY_W / 32;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [IDX_W-1:0]   cap_idx;
   logic               cap_wr;
   logic [ENTRY_W-1:0] cap_wdata;

   apb_tbl_port_if #(
      .ADDR_W (ADDR_W), .ENTRY_W (ENTRY_W), .IDX_W (IDX_W)
   ) bus ();

   apb_tbl_port #(
      .ADDR_W (ADDR_W), .ENTRY_W (ENTRY_W),
      .IDX_W (IDX_W), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_ctrl (clk),
      .rst_ctrl (rst),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apb(input bit wr, input logic [11:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
      bus.psel = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite = wr;
      bus.paddr = a;
      bus.pwdata = d;
      tick();
      bus.penable = 1'b1;
      tick();
      chk("pready", bus.pready, 1'b1);
      rd = bus.prdata;
      er = bus.pslverr;
      tick();
      bus.psel = 1'b0;
      bus.penable = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [11:0] a,
                         input logic [31:0] exp,
                         input bit exp_err);
      logic [31:0] r;
      logic e;
      apb(1'b0, a, 32'h0, r, e);
      chk({nm, "_data"}, r, exp);
      chk({nm, "_err"}, e, exp_err);
   endtask

   task automatic wr_chk(input string nm, input logic [11:0] a,
                         input logic [31:0] d,
                         input bit exp_err);
      logic [31:0] r;
      logic e;
      apb(1'b1, a, d, r, e);
      chk({nm, "_err"}, e, exp_err);
   endtask

   task automatic serve(input int rdy_dly, input int rsp_dly,
                        input bit err,
                        input logic [ENTRY_W-1:0] rdat);
      int n = 0;
      while (bus.tbl_req_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("req_seen", bus.tbl_req_valid, 1'b1);
      if (bus.tbl_req_valid === 1'b1) begin
         cap_idx = bus.tbl_req_idx;
         cap_wr = bus.tbl_req_wr;
         cap_wdata = bus.tbl_req_wdata;
         repeat (rdy_dly) tick();
         chk("req_held", bus.tbl_req_valid, 1'b1);
         bus.tbl_req_ready = 1'b1;
         tick();
         bus.tbl_req_ready = 1'b0;
         chk("req_drop", bus.tbl_req_valid, 1'b0);
         repeat (rsp_dly - 1) tick();
         bus.tbl_rsp_valid = 1'b1;
         bus.tbl_rsp_err = err;
         bus.tbl_rsp_rdata = rdat;
         tick();
         bus.tbl_rsp_valid = 1'b0;
         bus.tbl_rsp_err = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t               vt[14];
      logic [ENTRY_W-1:0] exp_w;
      logic [ENTRY_W-1:0] rpat;
      logic [31:0]        r;
      logic               e;

      vt[0]  = '{0, 12'h004, 0, 32'h0, 0};
      vt[1]  = '{0, 12'h000, 0, 32'h0, 0};
      vt[2]  = '{1, 12'h008, 32'h7FF, 0, 0};
      vt[3]  = '{0, 12'h008, 0, 32'h3FF, 0};
      vt[4]  = '{1, 12'h080, 32'h12345678, 0, 0};
      vt[5]  = '{0, 12'h080, 0, 32'h12345678, 0};
      vt[6]  = '{1, 12'h09C, 32'hCAFEF00D, 0, 0};
      vt[7]  = '{0, 12'h09C, 0, 32'hCAFEF00D, 0};
      vt[8]  = '{0, 12'h0A0, 0, 32'h0, 1};
      vt[9]  = '{1, 12'h0A0, 32'h1, 0, 1};
      vt[10] = '{0, 12'h200, 0, 32'h0, 1};
      vt[11] = '{0, 12'h00C, 0, 32'h0, 1};
      vt[12] = '{1, 12'h004, 32'h6, 0, 0};
      vt[13] = '{0, 12'h082, 0, 32'h12345678, 0};

      bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
      bus.paddr = '0; bus.pwdata = '0;
      bus.tbl_req_ready = 0; bus.tbl_rsp_valid = 0;
      bus.tbl_rsp_err = 0; bus.tbl_rsp_rdata = '0;

      repeat (3) tick();
      chk("rst_req_valid", bus.tbl_req_valid, 1'b0);
      chk("rst_pready", bus.pready, 1'b0);
      chk("rst_prdata", bus.prdata, 32'h0);
      chk("rst_pslverr", bus.pslverr, 1'b0);
      chk("rst_req_wr", bus.tbl_req_wr, 1'b0);
      chk("rst_req_idx", bus.tbl_req_idx, '0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         apb(vt[i].wr, vt[i].addr, vt[i].wdata, r, e);
         chk($sformatf("vec%0d_err", i), e, vt[i].exp_err);
         if (!vt[i].wr) chk($sformatf("vec%0d_rd", i), r, vt[i].exp_rd);
      end

      // T2 write op
      wr_chk("t2_idx", 12'h008, 32'd5, 0);
      exp_w = '0;
      for (int i = 0; i < NW; i++) begin
         wr_chk("t2_data", 12'(12'h080 + 4 * i), 32'(i) * 32'h11111111, 0);
         exp_w[32*i +: 32] = 32'(i) * 32'h11111111;
      end
      fork
         serve(3, 2, 1'b0, '0);
         wr_chk("t2_go", 12'h000, 32'h1, 0);
      join
      chk("t2_cap_idx", cap_idx, 10'd5);
      chk("t2_cap_wr", cap_wr, 1'b1);
      chk("t2_cap_wdata", cap_wdata, exp_w);
      rd_chk("t2_status", 12'h004, 32'h2, 0);

      // T3 read op
      for (int i = 0; i < NW; i++) rpat[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      fork
         serve(1, 1, 1'b0, rpat);
         wr_chk("t3_go", 12'h000, 32'h3, 0);
      join
      chk("t3_cap_wr", cap_wr, 1'b0);
      for (int i = 0; i < NW; i++)
         rd_chk("t3_data", 12'(12'h080 + 4 * i), 32'hA5A5_0000 + 32'(i), 0);
      rd_chk("t3_status", 12'h004, 32'h2, 0);
      rd_chk("t3_ctrl", 12'h000, 32'h2, 0);
      wr_chk("t3_w1c", 12'h004, 32'h2, 0);
      rd_chk("t3_status_clr", 12'h004, 32'h0, 0);

      // T4 busy with backpressure
      wr_chk("t4_go", 12'h000, 32'h1, 0);
      wr_chk("t4_data_busy", 12'h080, 32'hDEAD_BEEF, 1);
      rd_chk("t4_data_kept", 12'h080, 32'hA5A5_0000, 0);
      wr_chk("t4_idx_busy", 12'h008, 32'h3, 1);
      wr_chk("t4_ctrl_busy", 12'h000, 32'h3, 1);
      rd_chk("t4_unmapped", 12'h200, 32'h0, 1);
      rd_chk("t4_status", 12'h004, 32'h1, 0);
      rd_chk("t4_index", 12'h008, 32'h5, 0);
      chk("t4_valid_held", bus.tbl_req_valid, 1'b1);

      // T1 reset while REQ pending
      rst = 1'b1;
      #1;
      chk("t1_valid_async", bus.tbl_req_valid, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      rd_chk("t1_status", 12'h004, 32'h0, 0);
      rd_chk("t1_data_lost", 12'h080, 32'h0, 0);

      // T5 timeout with late response
      bus.tbl_req_ready = 1'b1;
      wr_chk("t5_go", 12'h000, 32'h3, 0);
      tick();
      bus.tbl_req_ready = 1'b0;
      repeat (TIMEOUT - 20) tick();
      rd_chk("t5_busy", 12'h004, 32'h1, 0);
      repeat (40) tick();
      rd_chk("t5_status", 12'h004, 32'h6, 0);
      bus.tbl_rsp_valid = 1'b1;
      bus.tbl_rsp_rdata = '1;
      tick();
      bus.tbl_rsp_valid = 1'b0;
      rd_chk("t5_late_status", 12'h004, 32'h6, 0);
      rd_chk("t5_late_data", 12'h080, 32'h0, 0);

      // T6 W1C racing a response with error
      bus.tbl_req_ready = 1'b1;
      wr_chk("t6_go", 12'h000, 32'h1, 0);
      tick();
      bus.tbl_req_ready = 1'b0;
      rd_chk("t6_busy", 12'h004, 32'h1, 0);
      bus.psel = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite = 1'b1;
      bus.paddr = 12'h004;
      bus.pwdata = 32'h6;
      tick();
      bus.penable = 1'b1;
      tick();
      chk("t6_pready", bus.pready, 1'b1);
      chk("t6_pslverr", bus.pslverr, 1'b0);
      bus.tbl_rsp_valid = 1'b1;
      bus.tbl_rsp_err = 1'b1;
      tick();
      bus.tbl_rsp_valid = 1'b0;
      bus.tbl_rsp_err = 1'b0;
      bus.psel = 1'b0;
      bus.penable = 1'b0;
      rd_chk("t6_status", 12'h004, 32'h6, 0);
      wr_chk("t6_w1c_err", 12'h004, 32'h4, 0);
      rd_chk("t6_status_done", 12'h004, 32'h2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
